mux_scan: RTL and testbench
===========================

# mux_scan

Parametrised, registered N-channel data multiplexer. It is the successor to the team's 4:1 single-bit line mux. It supports two modes. In manual mode, a channel is picked directly by `cntrl_sel`. In scan mode, the block steps round-robin through enabled channels, holding each for a programmable dwell time. It sits between the input line bank and downstream capture/display logic, and reports which channel is currently presented.

## Interface
Parameters:
- `WIDTH`, 8: data bits per channel (≥1)
- `CHANNELS`, 4: number of input channels (≥2)
- `SEL_W`, 2: select width; must equal clog2(CHANNELS)
- `DWELL`, 16: cycles each channel is held in scan mode (≥1)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `line_bus`  in  CHANNELS*WIDTH  channel data; channel k = bits [k*WIDTH +: WIDTH]
- `cntrl_sel`  in  SEL_W  manual-mode channel index
- `cntrl_mode`  in  1  0 = manual, 1 = scan
- `chan_mask`  in  CHANNELS  scan-mode enable per channel; bit k enables channel k
- `output_line`  out  WIDTH  registered selected data
- `output_valid`  out  1  output_line holds valid channel data
- `active_chan`  out  SEL_W  channel index whose data is on output_line
- `scan_wrap`  out  1  one-cycle pulse when the scan pointer wraps

## Operation
- FSM states:
  - MANUAL: cntrl_mode=0.
  - SCAN: cntrl_mode=1 and chan_mask≠0.
  - SCAN_EMPTY: cntrl_mode=1 and chan_mask=0.
- Transitions are evaluated every cycle from the current inputs.
- Reset state is MANUAL.

MANUAL:
- Valid select (cntrl_sel < CHANNELS): output_line ← line_bus[cntrl_sel], active_chan ← cntrl_sel, output_valid ← 1.
- Out-of-range select (non-power-of-2 CHANNELS): output_line ← 0, output_valid ← 0, active_chan ← 0.

SCAN:
- Internal pointer `cur` and dwell counter `dwell_cnt` (0..DWELL-1).
- Outputs each cycle: output_line ← line_bus[cur], active_chan ← cur, output_valid ← 1.
- Entry from MANUAL or SCAN_EMPTY:
  - cur ← lowest-index enabled channel; dwell_cnt ← 0.
  - The first output is that channel.
- Advance, when dwell_cnt = DWELL-1 or chan_mask[cur] = 0:
  - cur ← next enabled index after cur, searching modulo CHANNELS; dwell_cnt ← 0.
- Otherwise dwell_cnt increments.
- scan_wrap ← 1 for one cycle when an advance selects an index ≤ old cur. This includes the single-enabled-channel case, where cur is unchanged.

SCAN_EMPTY:
- output_line ← 0, output_valid ← 0, active_chan ← 0.
- dwell_cnt held at 0.

General:
- scan_wrap is 0 in MANUAL and SCAN_EMPTY.
- chan_mask is ignored in MANUAL. cntrl_sel is ignored in scan states.

## Timing
- Reset values: output_line=0, output_valid=0, active_chan=0, scan_wrap=0, cur=0, dwell_cnt=0, state=MANUAL.
- rst takes priority over every other input.
- Latency: one cycle from any input (line_bus, cntrl_sel, cntrl_mode, chan_mask) to registered outputs. No combinational path to outputs.
- Alignment: output_line, output_valid, active_chan and scan_wrap are updated on the same edge.
- Dwell period: in steady scan, each enabled channel is presented for exactly DWELL consecutive cycles.
  - DWELL=1 advances every cycle.
- Mask bit of cur cleared mid-dwell:
  - The next edge already shows the next enabled channel.
  - No stale cycle beyond the one-cycle latency.
- Mask change adding a channel: no effect until the next advance search.
- Mode 1→0: on the next edge, output follows cntrl_sel. The scan pointer is discarded.
- Mode 0→1: scan always restarts at the lowest enabled channel.
- rst asserted mid-dwell: next edge gives reset values. After rst is released, the first edge acts on current inputs.

## Test plan
Use WIDTH=8, CHANNELS=4, DWELL=4, and line_bus channels = 0x11, 0x22, 0x33, 0x44.

- Manual sweep: mode=0, cntrl_sel 3,2,1,0 on consecutive cycles -> output_line 0x44, 0x33, 0x22, 0x11, each one cycle later. active_chan matches; valid=1.
- Full scan: mode=1, mask=4'b1111 -> 0x11×4, 0x22×4, 0x33×4, 0x44×4, 0x11… scan_wrap pulses on the first 0x11 cycle after 0x44.
- Sparse mask: mask=4'b1010 -> channels 1,3 alternate, 4 cycles each. scan_wrap on each return to ch1.
  - mask=4'b0100 -> 0x33 constant; scan_wrap every 4th cycle.
- Mid-dwell mask drop: scanning ch1 at dwell_cnt=1, clear mask bit1 -> next edge active_chan=2, output 0x33, held 4 cycles.
- Empty and recover: mask=0 -> output_valid=0, output_line=0. Then mask=4'b1000 -> ch3 (0x44) appears one cycle later, valid=1.
- Reset mid-operation: assert rst during scan of ch2 -> all outputs 0 next edge. Release with mode=0, cntrl_sel=1 -> 0x22 next edge.

Source files
------------

// File: rtl/mux_scan.sv
// -----------------------------------------------------------------------------
// mux_scan
//
// Registered N-channel data multiplexer with two modes:
//   manual : the channel is picked directly by cntrl_sel
//   scan   : round-robin over the channels enabled in chan_mask, holding each
//            one for DWELL cycles
// Every output is a flop, so any input change reaches the outputs one edge
// later.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   line_bus     CHANNELS*WIDTH input data, channel k at [k*WIDTH +: WIDTH]
//   cntrl_sel    manual-mode channel index
//   cntrl_mode   0 = manual, 1 = scan
//   chan_mask    scan-mode per-channel enable
//   output_line  registered selected data
//   output_valid output_line holds real channel data
//   active_chan  index of the channel on output_line
//   scan_wrap    one-cycle pulse when a scan advance lands on an index <= the
//                previous one
//
// State table
//   state          | meaning
//   ST_MANUAL      | cntrl_mode = 0, output follows cntrl_sel
//   ST_SCAN        | cntrl_mode = 1, at least one channel enabled
//   ST_SCAN_EMPTY  | cntrl_mode = 1, no channel enabled, outputs idle
// -----------------------------------------------------------------------------
module mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   line_bus,
  input  logic [SEL_W-1:0]            cntrl_sel,
  input  logic                        cntrl_mode,
  input  logic [CHANNELS-1:0]         chan_mask,
  output logic [WIDTH-1:0]            output_line,
  output logic                        output_valid,
  output logic [SEL_W-1:0]            active_chan,
  output logic                        scan_wrap
);

  // A 1-bit counter is kept for DWELL = 1 so the compare still has a vector.
  localparam int                DCNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCNT_W-1:0] DWELL_LAST = DCNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_MANUAL     = 2'd0,
    ST_SCAN       = 2'd1,
    ST_SCAN_EMPTY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    cur_q, cur_d;
  logic [DCNT_W-1:0]   dwell_q, dwell_d;
  logic [WIDTH-1:0]    line_q, line_d;
  logic                valid_q, valid_d;
  logic [SEL_W-1:0]    act_q, act_d;
  logic                wrap_q, wrap_d;

  logic [WIDTH-1:0]    chan_data [CHANNELS];
  logic [SEL_W-1:0]    lowest_en;
  logic [SEL_W-1:0]    next_en;
  logic                sel_ok;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      chan_data[k] = line_bus[k*WIDTH +: WIDTH];
    end
  end

  // Lowest enabled index: scanning downward lets the smallest hit win.
  always_comb begin
    lowest_en = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (chan_mask[k]) begin
        lowest_en = SEL_W'(k);
      end
    end
  end

  // Next enabled index after cur_q, modulo CHANNELS. Offset CHANNELS maps back
  // to cur_q itself, which covers the single-enabled-channel case. Scanning
  // offsets downward lets the nearest hit win.
  always_comb begin
    next_en = cur_q;
    for (int off = CHANNELS; off >= 1; off--) begin
      if (chan_mask[(int'(cur_q) + off) % CHANNELS]) begin
        next_en = SEL_W'((int'(cur_q) + off) % CHANNELS);
      end
    end
  end

  assign sel_ok = (int'(cntrl_sel) < CHANNELS);

  always_comb begin
    state_d = state_q;
    cur_d   = '0;
    dwell_d = '0;
    line_d  = '0;
    valid_d = 1'b0;
    act_d   = '0;
    wrap_d  = 1'b0;

    if (!cntrl_mode) begin
      state_d = ST_MANUAL;
      if (sel_ok) begin
        line_d  = chan_data[cntrl_sel];
        valid_d = 1'b1;
        act_d   = cntrl_sel;
      end
    end else if (chan_mask == '0) begin
      state_d = ST_SCAN_EMPTY;
    end else begin
      state_d = ST_SCAN;
      if (state_q != ST_SCAN) begin
        // Fresh entry always restarts at the lowest enabled channel.
        cur_d   = lowest_en;
        dwell_d = '0;
      end else if ((dwell_q == DWELL_LAST) || !chan_mask[cur_q]) begin
        // Dwell expired, or the current channel was disabled mid-dwell.
        cur_d   = next_en;
        dwell_d = '0;
        wrap_d  = (next_en <= cur_q);
      end else begin
        cur_d   = cur_q;
        dwell_d = dwell_q + DCNT_W'(1);
      end
      line_d  = chan_data[cur_d];
      valid_d = 1'b1;
      act_d   = cur_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_MANUAL;
      cur_q   <= '0;
      dwell_q <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
      act_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dwell_q <= dwell_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      act_q   <= act_d;
      wrap_q  <= wrap_d;
    end
  end

  assign output_line  = line_q;
  assign output_valid = valid_q;
  assign active_chan  = act_q;
  assign scan_wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
module tb_mux_scan;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;
  localparam int DWELL    = 4;
  localparam logic [31:0] BUS_BASE = 32'h4433_2211;

  logic                      clk;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] line_bus;
  logic [SEL_W-1:0]          cntrl_sel;
  logic                      cntrl_mode;
  logic [CHANNELS-1:0]       chan_mask;
  logic [WIDTH-1:0]          output_line;
  logic                      output_valid;
  logic [SEL_W-1:0]          active_chan;
  logic                      scan_wrap;

  int total  = 0;
  int passed = 0;

  mux_scan #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DWELL(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .line_bus(line_bus), .cntrl_sel(cntrl_sel),
    .cntrl_mode(cntrl_mode), .chan_mask(chan_mask),
    .output_line(output_line), .output_valid(output_valid),
    .active_chan(active_chan), .scan_wrap(scan_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  mask;
    logic [31:0] bus;
    logic [7:0]  e_line;
    logic        e_valid;
    logic [1:0]  e_chan;
    logic        e_wrap;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [7:0] data_of(input int ch);
    return 8'((ch + 1) * 17);
  endfunction

  // Inputs are set between edges; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] e_line,
                       input logic e_valid, input logic [1:0] e_chan, input logic e_wrap);
    total++;
    if ({output_line, output_valid, active_chan, scan_wrap} === {e_line, e_valid, e_chan, e_wrap})
      passed++;
    else
      $display("FAIL %s[%0d]: got line=%h valid=%b chan=%0d wrap=%b, expected line=%h valid=%b chan=%0d wrap=%b",
               name, idx, output_line, output_valid, active_chan, scan_wrap,
               e_line, e_valid, e_chan, e_wrap);
  endtask

  initial begin
    int ch;
    logic w;

    rst = 1'b1; cntrl_mode = 1'b0; cntrl_sel = '0; chan_mask = '0; line_bus = BUS_BASE;

    //           rst   mode  sel   mask     bus            line   v     chan  wrap
    vecs[0] = '{1'b1, 1'b0, 2'd0, 4'b1111, BUS_BASE,      8'h00, 1'b0, 2'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 2'd3, 4'b1111, BUS_BASE,      8'h44, 1'b1, 2'd3, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 2'd2, 4'b1111, BUS_BASE,      8'h33, 1'b1, 2'd2, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 2'd1, 4'b1111, BUS_BASE,      8'h22, 1'b1, 2'd1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 2'd0, 4'b1111, BUS_BASE,      8'h11, 1'b1, 2'd0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 2'd2, 4'b0000, BUS_BASE,      8'h33, 1'b1, 2'd2, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 2'd1, 4'b0000, 32'h4433_A511, 8'hA5, 1'b1, 2'd1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 2'd3, 4'b1111, BUS_BASE,      8'h00, 1'b0, 2'd0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst; cntrl_mode = vecs[i].mode; cntrl_sel = vecs[i].sel;
      chan_mask = vecs[i].mask; line_bus = vecs[i].bus;
      tick();
      check("vec", i, vecs[i].e_line, vecs[i].e_valid, vecs[i].e_chan, vecs[i].e_wrap);
    end
    rst = 1'b0; line_bus = BUS_BASE;

    // Full scan: 4 cycles per channel, wrap on the first ch0 cycle after ch3.
    cntrl_mode = 1'b1; chan_mask = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      ch = (i / 4) % 4;
      w  = (i == 16);
      check("full_scan", i, data_of(ch), 1'b1, 2'(ch), w);
    end

    // Scan -> manual follows cntrl_sel on the next edge.
    cntrl_mode = 1'b0; cntrl_sel = 2'd3;
    tick();
    check("mode_1to0", 0, 8'h44, 1'b1, 2'd3, 1'b0);

    // Sparse mask 1010: ch1 and ch3 alternate, wrap on each return to ch1.
    cntrl_mode = 1'b1; chan_mask = 4'b1010;
    for (int i = 0; i < 17; i++) begin
      tick();
      ch = ((i / 4) % 2 == 1) ? 3 : 1;
      w  = (i > 0) && (i % 8 == 0);
      check("sparse_1010", i, data_of(ch), 1'b1, 2'(ch), w);
    end

    // Single channel: ch2 constant, wrap every 4th cycle.
    cntrl_mode = 1'b0;
    tick();
    cntrl_mode = 1'b1; chan_mask = 4'b0100;
    for (int i = 0; i < 13; i++) begin
      tick();
      w = (i > 0) && (i % 4 == 0);
      check("single_0100", i, 8'h33, 1'b1, 2'd2, w);
    end

    // Mid-dwell drop: ch1 at dwell 1, clear bit1 -> ch2 next edge for 4 cycles.
    cntrl_mode = 1'b0;
    tick();
    cntrl_mode = 1'b1; chan_mask = 4'b1110;
    tick();
    check("drop_pre", 0, 8'h22, 1'b1, 2'd1, 1'b0);
    tick();
    check("drop_pre", 1, 8'h22, 1'b1, 2'd1, 1'b0);
    chan_mask = 4'b1100;
    for (int i = 0; i < 9; i++) begin
      tick();
      ch = (i < 4) ? 2 : ((i < 8) ? 3 : 2);
      w  = (i == 8);
      check("drop_post", i, data_of(ch), 1'b1, 2'(ch), w);
    end

    // Empty mask, then recovery onto ch3.
    chan_mask = 4'b0000;
    tick();
    check("empty", 0, 8'h00, 1'b0, 2'd0, 1'b0);
    tick();
    check("empty", 1, 8'h00, 1'b0, 2'd0, 1'b0);
    chan_mask = 4'b1000;
    tick();
    check("recover", 0, 8'h44, 1'b1, 2'd3, 1'b0);
    tick();
    check("recover", 1, 8'h44, 1'b1, 2'd3, 1'b0);

    // Disabling cur (ch3) advances to ch2, which is <= 3, so it wraps.
    chan_mask = 4'b0100;
    tick();
    check("mask_swap", 0, 8'h33, 1'b1, 2'd2, 1'b1);
    tick();
    check("mask_swap", 1, 8'h33, 1'b1, 2'd2, 1'b0);

    // Reset mid-dwell of ch2, then release into manual sel=1.
    rst = 1'b1; cntrl_mode = 1'b0; cntrl_sel = 2'd1;
    tick();
    check("rst_mid", 0, 8'h00, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    check("rst_release", 0, 8'h22, 1'b1, 2'd1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
